// File: rtl/ledmatrix_pattern_gen.sv
// Frame source for the PMOD LED matrix: steps a ROWS x COLS frame on a
// prescaled tick using one of four run-time selectable patterns. A step
// request is held until the display signals frame_ready, and a host load
// overrides any step in the same cycle.
module ledmatrix_pattern_gen #(
    parameter int          ROWS   = 8,
    parameter int          COLS   = 8,
    parameter int          PERIOD = 600000,
    parameter logic [63:0] TAPS   = 64'h800000000000000d,
    parameter logic [63:0] INIT   = 64'h8000000000000001
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             mode,
    input  logic                   pause,
    input  logic                   load,
    input  logic [ROWS*COLS-1:0]   load_data,
    input  logic                   frame_ready,
    output logic [ROWS*COLS-1:0]   pixels,
    output logic                   frame_update,
    output logic [15:0]            frame_count
);

    localparam int N  = ROWS * COLS;
    localparam int CW = $clog2(PERIOD + 1);

    // Parameter masks resized to the frame width (truncate or zero-extend).
    localparam logic [N-1:0]  TAPS_N    = N'(TAPS);
    localparam logic [N-1:0]  INIT_N    = N'(INIT);
    localparam logic [N-1:0]  ONE_N     = N'(1);
    localparam logic [CW-1:0] RELOAD    = CW'(PERIOD - 1);

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'd0,
        MODE_LFSR   = 2'd1,
        MODE_WALK   = 2'd2,
        MODE_SCROLL = 2'd3
    } mode_t;

    logic [CW-1:0] cnt;
    logic          pending;
    logic          tick;
    logic          step_req;
    logic          advance;
    logic          commit_step;
    logic [N-1:0]  next_frame;

    // Step request: a fresh tick or one that is still waiting for the display.
    always_comb begin
        tick        = ~pause & (cnt == '0);
        step_req    = tick | pending;
        advance     = step_req & frame_ready;
        commit_step = advance & (mode_t'(mode) != MODE_HOLD);
    end

    // Next frame for the selected pattern; all-zero frames re-seed where a
    // pattern would otherwise lock up (scroll keeps an empty frame empty).
    always_comb begin
        next_frame = pixels;
        case (mode_t'(mode))
            MODE_LFSR:   next_frame = (pixels == '0) ? INIT_N
                                      : {pixels[N-2:0], ^(pixels & TAPS_N)};
            MODE_WALK:   next_frame = (pixels == '0) ? ONE_N
                                      : {pixels[N-2:0], pixels[N-1]};
            MODE_SCROLL: begin
                for (int r = 0; r < ROWS; r++) begin
                    next_frame[r*COLS +: COLS] =
                        {pixels[r*COLS +: COLS-1], pixels[r*COLS + COLS - 1]};
                end
            end
            default:     next_frame = pixels;
        endcase
    end

    // Prescaler, pending request, frame register and commit bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt          <= '0;
            pending      <= 1'b0;
            pixels       <= INIT_N;
            frame_update <= 1'b0;
            frame_count  <= 16'd0;
        end else if (load) begin
            // Host load wins; a coincident tick is dropped and the cadence restarts.
            cnt          <= RELOAD;
            pending      <= 1'b0;
            pixels       <= load_data;
            frame_update <= 1'b1;
            frame_count  <= frame_count + 16'd1;
        end else begin
            if (!pause) begin
                cnt <= (cnt == '0) ? RELOAD : cnt - CW'(1);
            end
            pending      <= step_req & ~frame_ready;
            frame_update <= commit_step;
            if (commit_step) begin
                pixels      <= next_frame;
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ledmatrix_pattern_gen.sv
// Self-checking bench for ledmatrix_pattern_gen (8x8, short tick period).
// A behavioural model tracks the frame, pending request and commit count
// from the pattern rules; directed steps cover the documented scenarios and
// a randomized phase mixes modes, pause, back-pressure and loads.
module tb_ledmatrix_pattern_gen;

    localparam int          PERIOD = 4;
    localparam logic [63:0] TAPS   = 64'h800000000000000d;
    localparam logic [63:0] INIT   = 64'h8000000000000001;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic        pause;
    logic        load;
    logic [63:0] load_data;
    logic        frame_ready;
    logic [63:0] pixels;
    logic        frame_update;
    logic [15:0] frame_count;

    ledmatrix_pattern_gen #(
        .ROWS(8), .COLS(8), .PERIOD(PERIOD), .TAPS(TAPS), .INIT(INIT)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .pause(pause), .load(load),
        .load_data(load_data), .frame_ready(frame_ready), .pixels(pixels),
        .frame_update(frame_update), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state.
    logic [63:0] m_pix;
    logic        m_upd;
    logic [15:0] m_cnt;
    logic        m_pend;
    int          elapsed;   // unpaused cycles since the cadence anchor

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [63:0] pattern_next(input logic [1:0] md, input logic [63:0] p);
        logic [63:0] q;
        logic [7:0]  row;
        case (md)
            2'd1: q = (p == 0) ? INIT : ((p << 1) | 64'($countones(p & TAPS) % 2));
            2'd2: q = (p == 0) ? 64'd1 : ((p << 1) | (p >> 63));
            2'd3: begin
                q = 0;
                for (int r = 0; r < 8; r++) begin
                    row = 8'((p >> (8 * r)) & 64'hFF);
                    row = 8'((row << 1) | (row >> 7));
                    q   = q | (64'(row) << (8 * r));
                end
            end
            default: q = p;
        endcase
        return q;
    endfunction

    task automatic model_reset();
        m_pix = INIT; m_upd = 0; m_cnt = 0; m_pend = 0; elapsed = 0;
    endtask

    // One clock: predict from current inputs, clock, then compare.
    task automatic cyc();
        logic tk, req;
        logic [63:0] n_pix;
        logic        n_upd, n_pend;
        logic [15:0] n_cnt;
        tk    = !pause && (elapsed % PERIOD == 0);
        req   = tk || m_pend;
        n_pix = m_pix; n_upd = 0; n_cnt = m_cnt; n_pend = m_pend;
        if (load) begin
            n_pix = load_data; n_upd = 1; n_cnt = m_cnt + 16'd1; n_pend = 0;
        end else if (req && frame_ready) begin
            n_pend = 0;
            if (mode != 2'd0) begin
                n_pix = pattern_next(mode, m_pix); n_upd = 1; n_cnt = m_cnt + 16'd1;
            end
        end else begin
            n_pend = req;
        end
        if (load) elapsed = 1;
        else if (!pause) elapsed++;
        @(posedge clk); #1;
        m_pix = n_pix; m_upd = n_upd; m_cnt = n_cnt; m_pend = n_pend;
        chk("pixels", pixels, m_pix);
        chk("frame_update", 64'(frame_update), 64'(m_upd));
        chk("frame_count", 64'(frame_count), 64'(m_cnt));
    endtask

    task automatic do_load(input logic [63:0] d);
        load = 1; load_data = d; cyc(); load = 0;
    endtask

    logic [15:0] snap;

    initial begin
        rst = 0; mode = 2'd1; pause = 0; load = 0; load_data = 0; frame_ready = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pixels", pixels, INIT);
        chk("reset_update", 64'(frame_update), 64'd0);
        chk("reset_count", 64'(frame_count), 64'd0);
        #2 rst = 1;
        @(negedge clk);
        @(posedge clk); #1;       // realign: first model cycle starts here
        // Reset released before this edge, so the tick has already fired once.
        m_pix = pattern_next(2'd1, INIT); m_upd = 1; m_cnt = 1; elapsed = 1;
        chk("lfsr_first", pixels, 64'h2);
        chk("lfsr_first_cnt", 64'(frame_count), 64'd1);
        repeat (PERIOD) cyc();
        chk("lfsr_second", pixels, 64'h4);
        chk("lfsr_second_cnt", 64'(frame_count), 64'd2);

        // Walking pixel wraps from the top bit and re-seeds from zero.
        mode = 2'd2;
        do_load(64'h8000000000000000);
        repeat (PERIOD) cyc();
        chk("walk_wrap", pixels, 64'h1);
        repeat (PERIOD) cyc();
        chk("walk_step", pixels, 64'h2);
        do_load(64'h0);
        repeat (PERIOD) cyc();
        chk("walk_zero", pixels, 64'h1);

        // Per-row scroll.
        mode = 2'd3;
        do_load(64'h000000000000F081);
        repeat (PERIOD) cyc();
        chk("scroll_rows", pixels, 64'h000000000000E103);

        // Back-pressure: ticks collapse into one pending request.
        mode = 2'd1;
        frame_ready = 0;
        snap = m_cnt;
        repeat (3 * PERIOD) cyc();
        chk("stall_count", 64'(frame_count), 64'(snap));
        frame_ready = 1;
        cyc();
        chk("stall_release", 64'(frame_count), 64'(snap + 16'd1));

        // Load coinciding with a tick, then HOLD consumes ticks silently.
        while (elapsed % PERIOD != 0) cyc();
        do_load(64'hDEADBEEF);
        chk("load_tick", pixels, 64'hDEADBEEF);
        mode = 2'd0;
        snap = m_cnt;
        repeat (3 * PERIOD) cyc();
        chk("hold_count", 64'(frame_count), 64'(snap));
        chk("hold_pixels", pixels, 64'hDEADBEEF);

        // Randomized mix of modes, pause, readiness and loads.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            pause       = ($urandom_range(0, 9) == 0);
            frame_ready = ($urandom_range(0, 9) < 7);
            load        = ($urandom_range(0, 29) == 0);
            load_data   = ($urandom_range(0, 3) == 0) ? 64'h0 : {$urandom, $urandom};
            cyc();
        end
        load = 0; pause = 0; frame_ready = 1;

        // Asynchronous reset between edges.
        repeat (3) cyc();
        #2 rst = 0;
        #1;
        chk("async_pixels", pixels, INIT);
        chk("async_count", 64'(frame_count), 64'd0);
        chk("async_update", 64'(frame_update), 64'd0);
        @(posedge clk); #1;
        model_reset();
        rst = 1;

        // Counter wrap through 65536 loads.
        load = 1;
        for (int i = 0; i < 65536; i++) begin
            load_data = {$urandom, $urandom};
            cyc();
        end
        load = 0;
        chk("count_wrap", 64'(frame_count), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
